// File: rtl/nac_mem_arbiter.sv
// nac_mem_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one burst master.
//   Only one burst is outstanding at a time. Each burst runs IDLE -> ISSUE -> WAIT -> DONE.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET      : clock and asynchronous active-high reset
//   req_valid/we/addr/len         : per-requester command; held until req_gnt
//   req_wdata/req_wvalid          : per-requester write stream
//   req_gnt                       : one-cycle pulse in the cycle the command is captured
//   req_wready/rvalid/rlast       : per-requester handshakes, routed to the owner only
//   req_rdata                     : read data, broadcast to every requester
//   req_done/req_error            : completion pulse and per-requester error status
//   sys_req/addr/len/we           : start pulse and registered command to the master
//   sys_wdata/wvalid/wready       : owner write stream to and from the master
//   sys_grant/valid/last/rdata/error : master status and read data
module nac_mem_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_len,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_wvalid,
  output logic [NUM_REQ-1:0]     req_gnt,
  output logic [NUM_REQ-1:0]     req_wready,
  output logic [NUM_REQ-1:0]     req_rvalid,
  output logic [NUM_REQ-1:0]     req_rlast,
  output logic [31:0]            req_rdata,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_error,
  output logic                   sys_req,
  output logic [31:0]            sys_addr,
  output logic [7:0]             sys_len,
  output logic                   sys_we,
  output logic [31:0]            sys_wdata,
  output logic                   sys_wvalid,
  input  logic                   sys_wready,
  input  logic                   sys_grant,
  input  logic                   sys_valid,
  input  logic                   sys_last,
  input  logic [31:0]            sys_rdata,
  input  logic                   sys_error
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] owner, last_winner, win_idx;
  logic          win_found;
  logic          cmpl;
  logic          wr_act, rd_act;

  logic [31:0] addr_a  [NUM_REQ];
  logic [7:0]  len_a   [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_a[g]  = req_addr[32*g +: 32];
    assign len_a[g]   = req_len[8*g +: 8];
    assign wdata_a[g] = req_wdata[32*g +: 32];
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Round-robin search. It starts one past the last winner, so a requester
  // that just finished has the lowest priority on its next request.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_i;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_i    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand   = (int'(last_winner) + 1 + k) % NUM_REQ;
      cand_i = IW'(cand);
      if (!win_found && req_valid[cand_i]) begin
        win_found = 1'b1;
        win_idx   = cand_i;
      end
    end
  end

  // A write completes on sys_grant. A read completes on its last beat.
  // On a read, sys_grant only means the address was accepted.
  assign cmpl = sys_we ? sys_grant : (sys_valid & sys_last);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_found) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (cmpl) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state       <= S_IDLE;
      owner       <= '0;
      last_winner <= IW'(NUM_REQ - 1);
      sys_addr    <= '0;
      sys_len     <= '0;
      sys_we      <= 1'b0;
      req_done    <= '0;
      req_error   <= '0;
    end else begin
      state    <= state_nx;
      req_done <= '0;
      case (state)
        S_IDLE: if (win_found) begin
          owner    <= win_idx;
          sys_addr <= addr_a[win_idx];
          sys_len  <= len_a[win_idx];
          sys_we   <= req_we[win_idx];
        end
        S_WAIT: if (cmpl) req_error[owner] <= sys_error;
        S_DONE: begin
          req_done    <= onehot(owner);
          last_winner <= owner;
        end
        default: ;
      endcase
    end
  end

  // The grant is combinational in the capture cycle. It is masked during
  // reset because state is already IDLE while reset is asserted.
  assign req_gnt = (state == S_IDLE && win_found && !M_AXI_ARESET) ? onehot(win_idx) : '0;
  assign sys_req = (state == S_ISSUE);

  assign wr_act = ((state == S_ISSUE) || (state == S_WAIT)) && sys_we;
  assign rd_act = (state == S_WAIT) && !sys_we;

  assign sys_wdata  = wr_act ? wdata_a[owner] : '0;
  assign sys_wvalid = wr_act && req_wvalid[owner];
  assign req_wready = (wr_act && sys_wready) ? onehot(owner) : '0;

  assign req_rdata  = sys_rdata;
  assign req_rvalid = (rd_act && sys_valid) ? onehot(owner) : '0;
  assign req_rlast  = (rd_act && sys_last)  ? onehot(owner) : '0;

endmodule

// File: tb/tb_nac_mem_arbiter.sv
// Scoreboard bench for nac_mem_arbiter. A behavioural burst master answers
// sys_req. Requesters are driven from the main process. The expected
// grants, commands, beats, write words and completions are queued as each
// request is set up, then popped as the DUT produces them.
module tb_nac_mem_arbiter;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_we, req_wvalid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    req_gnt, req_wready, req_rvalid, req_rlast, req_done, req_error;
  logic [31:0]     req_rdata, sys_addr, sys_wdata, sys_rdata;
  logic [7:0]      sys_len;
  logic            sys_req, sys_we, sys_wvalid;
  logic            sys_wready, sys_grant, sys_valid, sys_last, sys_error;

  always #5 clk = ~clk;

  nac_mem_arbiter #(.NUM_REQ(N)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid),
    .req_gnt(req_gnt), .req_wready(req_wready), .req_rvalid(req_rvalid),
    .req_rlast(req_rlast), .req_rdata(req_rdata), .req_done(req_done),
    .req_error(req_error),
    .sys_req(sys_req), .sys_addr(sys_addr), .sys_len(sys_len), .sys_we(sys_we),
    .sys_wdata(sys_wdata), .sys_wvalid(sys_wvalid), .sys_wready(sys_wready),
    .sys_grant(sys_grant), .sys_valid(sys_valid), .sys_last(sys_last),
    .sys_rdata(sys_rdata), .sys_error(sys_error)
  );

  typedef struct {int idx; logic [31:0] addr; logic [7:0] len; logic we;} cmd_t;
  typedef struct {int idx; logic [31:0] data; logic last;} beat_t;
  typedef struct {int idx; logic [31:0] data;} word_t;
  typedef struct {int idx; logic err;} done_t;

  cmd_t  q_cmd[$];
  beat_t q_beat[$];
  word_t q_word[$];
  done_t q_done[$];
  cmd_t  cur;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- burst master model ----------------
  logic        err_cfg = 1'b0, early_gnt = 1'b0, m_wact = 1'b0;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_we;
  int          nw;

  initial begin
    sys_wready = 0; sys_grant = 0; sys_valid = 0; sys_last = 0; sys_rdata = 0; sys_error = 0;
    forever begin
      @(negedge clk);
      if (sys_req && !rst) begin
        m_addr = sys_addr; m_len = sys_len; m_we = sys_we;
        if (!m_we) begin
          @(posedge clk); #1;
          if (early_gnt) begin sys_grant = 1; @(posedge clk); #1; sys_grant = 0; end
          for (int b = 0; b <= int'(m_len); b++) begin
            if (rst) break;
            sys_valid = 1;
            sys_rdata = m_addr + 32'(4 * b);
            sys_last  = (b == int'(m_len));
            sys_error = (b == int'(m_len)) ? err_cfg : 1'b0;
            @(posedge clk); #1;
          end
          sys_valid = 0; sys_last = 0; sys_error = 0;
        end else begin
          m_wact = 1; nw = 0;
          @(posedge clk); #1;
          sys_wready = 1;
          while (nw <= int'(m_len) && !rst) begin
            @(negedge clk);
            if (sys_wvalid) nw++;
            @(posedge clk); #1;
          end
          sys_wready = 0;
          if (!rst) begin
            sys_grant = 1; sys_error = err_cfg;
            @(posedge clk); #1;
          end
          sys_grant = 0; sys_error = 0; m_wact = 0;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  int     cyc = 0, last_gnt = -10, last_cmpl = -10, outst = 0, nbeats = 0;
  logic [N-1:0] exp_err = '0;

  always @(negedge clk) begin
    beat_t b; word_t w; done_t d;
    cyc++;
    if (rst) outst = 0;
    else begin
      if (req_gnt != 0) begin
        last_gnt = cyc;
        if (q_cmd.size() == 0) chk("gnt_unexpected", 32'(req_gnt), 0);
        else begin cur = q_cmd.pop_front(); chk("gnt", 32'(req_gnt), 32'(1) << cur.idx); end
      end
      if (sys_req) begin
        chk("req_latency", cyc - last_gnt, 1);
        chk("outstanding", outst, 0);
        outst = 1;
        chk("sys_addr", sys_addr, cur.addr);
        chk("sys_len", 32'(sys_len), 32'(cur.len));
        chk("sys_we", 32'(sys_we), 32'(cur.we));
      end
      if (req_rvalid != 0) begin
        nbeats++;
        if (q_beat.size() == 0) chk("beat_unexpected", 32'(req_rvalid), 0);
        else begin
          b = q_beat.pop_front();
          chk("rvalid", 32'(req_rvalid), 32'(1) << b.idx);
          chk("rdata", req_rdata, b.data);
          chk("rlast", 32'(req_rlast), b.last ? (32'(1) << b.idx) : 0);
        end
        if (req_rlast != 0) last_cmpl = cyc;
      end
      if (sys_wvalid && sys_wready) begin
        if (q_word.size() == 0) chk("word_unexpected", sys_wdata, 0);
        else begin
          w = q_word.pop_front();
          chk("wready", 32'(req_wready), 32'(1) << w.idx);
          chk("wdata", sys_wdata, w.data);
        end
      end
      if (sys_grant && m_wact) last_cmpl = cyc;
      if (req_done != 0) begin
        if (q_done.size() == 0) chk("done_unexpected", 32'(req_done), 0);
        else begin
          d = q_done.pop_front();
          exp_err[d.idx] = d.err;
          chk("done", 32'(req_done), 32'(1) << d.idx);
          chk("error_vec", 32'(req_error), 32'(exp_err));
          chk("done_latency", cyc - last_cmpl, 2);
        end
        outst = 0;
      end
    end
  end

  // ---------------- requester driver ----------------
  int          cnt[N], wptr[N], wtot[N];
  logic [31:0] wbuf[N][16];

  task automatic drive_w();
    for (int i = 0; i < N; i++) begin
      req_wvalid[i]         = (wptr[i] < wtot[i]);
      req_wdata[32*i +: 32] = wbuf[i][wptr[i][3:0]];
    end
  endtask

  task automatic cyc1();
    logic [N-1:0] g, a;
    @(negedge clk);
    g = req_gnt; a = req_wready & req_wvalid;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (a[i]) wptr[i]++;
      if (g[i]) begin cnt[i]--; if (cnt[i] <= 0) req_valid[i] = 1'b0; end
    end
    drive_w();
  endtask

  task automatic exp_burst(input int i, input logic we, input logic [31:0] addr,
                           input logic [7:0] len, input logic err);
    q_cmd.push_back('{i, addr, len, we});
    for (int b = 0; b <= int'(len); b++) begin
      if (!we) q_beat.push_back('{i, addr + 32'(4 * b), b == int'(len)});
      else     q_word.push_back('{i, wbuf[i][b[3:0]]});
    end
    q_done.push_back('{i, err});
  endtask

  task automatic arm(input int i, input logic we, input logic [31:0] addr,
                     input logic [7:0] len, input int bursts);
    req_we[i] = we; req_addr[32*i +: 32] = addr; req_len[8*i +: 8] = len;
    cnt[i] = bursts; wptr[i] = 0; wtot[i] = we ? (int'(len) + 1) * bursts : 0;
    req_valid[i] = 1'b1;
    drive_w();
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((q_cmd.size() + q_beat.size() + q_word.size() + q_done.size() != 0 || req_valid != 0)
           && k < maxc) begin
      cyc1(); k++;
    end
    chk("drain_timeout", 32'(k >= maxc), 0);
    if (k >= maxc) begin
      q_cmd.delete(); q_beat.delete(); q_word.delete(); q_done.delete(); req_valid = '0;
    end
    cyc1();
  endtask

  initial begin
    int k, base;
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base;
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0; req_wvalid = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; wptr[i] = 0; wtot[i] = 0;
      for (int j = 0; j < 16; j++) wbuf[i][j] = 32'h0; end
    repeat (2) @(posedge clk); #1;
    // reset state, with requests pending to prove req_gnt is held low
    req_valid = '1; #1;
    chk("rst_gnt", 32'(req_gnt), 0);
    chk("rst_sys_req", 32'(sys_req), 0);
    chk("rst_addr", sys_addr, 0);
    chk("rst_len", 32'(sys_len), 0);
    chk("rst_we", 32'(sys_we), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_error", 32'(req_error), 0);
    chk("rst_wvalid", 32'(sys_wvalid), 0);
    req_valid = '0;
    @(posedge clk); #1; rst = 0;

    // single read: requester 1, len 3
    exp_burst(1, 0, 32'h1000, 8'd3, 0); arm(1, 0, 32'h1000, 8'd3, 1); drain(200);
    // single write: requester 0, two words
    wbuf[0][0] = 32'hA5A5A5A5; wbuf[0][1] = 32'h5A5A5A5A;
    exp_burst(0, 1, 32'h2000, 8'd1, 0); arm(0, 1, 32'h2000, 8'd1, 1); drain(200);
    chk("wr_err0", 32'(req_error[0]), 0);
    // read with an early address-phase sys_grant
    early_gnt = 1;
    exp_burst(0, 0, 32'h3000, 8'd2, 0); arm(0, 0, 32'h3000, 8'd2, 1); drain(200);
    early_gnt = 0;
    // error on a write from requester 2, then a clean write clears it
    wbuf[2][0] = 32'hDEAD0002; err_cfg = 1;
    exp_burst(2, 1, 32'h4000, 8'd0, 1); arm(2, 1, 32'h4000, 8'd0, 1); drain(200);
    chk("err_set", 32'(req_error), 32'b100);
    wbuf[2][0] = 32'hBEEF0002; err_cfg = 0;
    exp_burst(2, 1, 32'h4004, 8'd0, 0); arm(2, 1, 32'h4004, 8'd0, 1); drain(200);
    chk("err_clear", 32'(req_error), 0);
    // length boundaries
    exp_burst(1, 0, 32'h5000, 8'd255, 0); arm(1, 0, 32'h5000, 8'd255, 1); drain(800);
    exp_burst(2, 0, 32'h6000, 8'd0, 0); arm(2, 0, 32'h6000, 8'd0, 1); drain(200);

    // contention from reset: grant order 0,1,2,0
    rst = 1; @(posedge clk); #1; rst = 0;
    exp_burst(0, 0, 32'h100, 8'd1, 0); exp_burst(1, 0, 32'h200, 8'd1, 0);
    exp_burst(2, 0, 32'h300, 8'd1, 0); exp_burst(0, 0, 32'h100, 8'd1, 0);
    arm(0, 0, 32'h100, 8'd1, 2); arm(1, 0, 32'h200, 8'd1, 1); arm(2, 0, 32'h300, 8'd1, 1);
    drain(400);

    // reset in the middle of a 16-beat read
    base = nbeats;
    exp_burst(1, 0, 32'h7000, 8'd15, 0); arm(1, 0, 32'h7000, 8'd15, 1);
    k = 0;
    while (nbeats < base + 5 && k < 100) begin cyc1(); k++; end
    chk("rd_start_timeout", 32'(k >= 100), 0);
    #2; rst = 1; #1;
    chk("mid_rvalid", 32'(req_rvalid), 0);
    chk("mid_rlast", 32'(req_rlast), 0);
    chk("mid_done", 32'(req_done), 0);
    chk("mid_sys_req", 32'(sys_req), 0);
    chk("mid_addr", sys_addr, 0);
    chk("mid_len", 32'(sys_len), 0);
    chk("mid_error", 32'(req_error), 0);
    q_cmd.delete(); q_beat.delete(); q_word.delete(); q_done.delete();
    req_valid = '0; exp_err = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; wtot[i] = 0; end
    drive_w();
    repeat (2) @(posedge clk);
    @(negedge clk); chk("rst_hold_done", 32'(req_done), 0);
    @(posedge clk); #1; rst = 0;
    // pointer back at 0: requester 0 beats requester 1
    exp_burst(0, 0, 32'h8000, 8'd0, 0); exp_burst(1, 0, 32'h9000, 8'd0, 0);
    arm(0, 0, 32'h8000, 8'd0, 1); arm(1, 0, 32'h9000, 8'd0, 1);
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
